commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
- Hardware retire-trace capture block that sits directly downstream of the processor's commit/writeback signals: PC, instruction, register-write, memory-access and halt indications.
- Each cycle it classifies the retiring instruction and packs a trace record. Records are buffered in a FIFO and drained through a valid/ready port to a trace sink (on-chip log RAM or debug UART).
- On halt it emits a terminal HALT record, stops accepting, and raises done once the FIFO has drained.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the instruction counter and the drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (0 = reset)
- commit_valid  in  1  an instruction retires this cycle
- pc  in  16  PC of the retiring instruction
- inst  in  16  instruction word (carried for debug; not stored)
- reg_write  in  1  register file write this cycle
- write_reg  in  3  destination register
- write_data  in  16  register write data
- mem_read  in  1  load this cycle
- mem_write  in  1  store this cycle
- mem_addr  in  16  memory address
- mem_data  in  16  store data
- halt  in  1  halt retiring
- out_valid  out  1  record available
- out_ready  in  1  sink accepts the record
- out_kind  out  3  record kind
- out_inum  out  CNT_W  instruction number
- out_pc, out_rdata, out_addr, out_mdata  out  16 each  record fields
- out_reg  out  3  destination register
- inst_count  out  CNT_W  instructions retired
- drop_cnt  out  CNT_W  records dropped, saturating
- overflow  out  1  sticky; set on any drop
- done  out  1  halt record drained

Behaviour:
- Reset (rst=0 at a clk edge): FIFO empty, state RUN. All outputs are 0, including out_valid, inst_count, drop_cnt, overflow and done. A reset asserted mid-operation discards all pending records.
- Kind classification, evaluated in priority order:
  1. reg_write & mem_write -> STU(5)
  2. reg_write & mem_read -> LD(3)
  3. reg_write -> REG(2)
  4. halt -> HALT(6)
  5. mem_write -> ST(4)
  6. otherwise -> NOP(1)
- Fields not relevant to a kind are stored as 0.
- out_inum = inst_count before increment. inst_count increments by 1 on every accepted commit_valid cycle and wraps modulo 2^CNT_W.
- FIFO protocol:
  - Enqueue happens on the clk edge where commit_valid=1 in RUN.
  - out_* fields are registered; an enqueue into an empty FIFO gives out_valid=1 on the next cycle (no bypass).
  - A dequeue occurs when out_valid & out_ready. out_* must stay stable while out_valid=1 and out_ready=0.
  - Simultaneous enqueue and dequeue while full: both succeed and count is unchanged.
- Overflow: a non-HALT record that arrives when the FIFO is full and there is no simultaneous dequeue is dropped.
  - drop_cnt increments, saturating at all-ones.
  - overflow sets and stays set until reset.
  - inst_count still increments.
- State machine:
  - RUN -> HALT_PEND when a HALT-kind record is seen and cannot enqueue. The HALT record is held in a one-entry skid register and retried every cycle; it is never dropped.
  - RUN -> DRAIN when the HALT record enqueues.
  - HALT_PEND -> DRAIN when the held record enqueues.
  - DRAIN -> DONE when the FIFO is empty.
  - DONE holds until reset; done=1 only in DONE.
  - In HALT_PEND, DRAIN and DONE, commit_valid is ignored and inst_count freezes.
- halt with reg_write=1 classifies as REG/LD/STU (per priority) and does not trigger halting; the processor must not assert both.

Decomposition:
- Shared package trace_pkg:
  - kind localparams: NOP=1, REG=2, LD=3, ST=4, STU=5, HALT=6 (0 reserved)
  - REC_W = 3 + CNT_W + 16 + 3 + 16 + 16 + 16
  - state encodings RUN/HALT_PEND/DRAIN/DONE
- Sub-module trace_fifo (DEPTH, REC_W; synchronous, active-low reset, full/empty flags) holds the packed records.
- The top level contains the classifier, counters, skid register and FSM.

Test Plan:
- Reset then 3 commits (REG r3=0x1234 @pc 0x0000; LD r1=0x00AA addr 0x0100 @0x0002; ST addr 0x0200 data 0xBEEF @0x0004), out_ready=1 -> records kinds 2,3,4 with inum 0,1,2 and exact fields; inst_count=3; out_valid first high 1 cycle after the first commit.
- out_ready=0, 10 NOP commits with DEPTH=8 -> 8 records held, drop_cnt=2, overflow=1, inst_count=10; releasing ready yields inum 0..7 in order.
- FIFO full, then commit and out_ready=1 in the same cycle -> no drop, drop_cnt unchanged, new record appears after the 7 older ones.
- HALT commit @pc 0x0010 with FIFO full and out_ready=0 for 5 cycles -> state HALT_PEND, further commits ignored; after ready=1 the HALT record is delivered last with inum=N; done=1 the cycle after the FIFO empties.
- Reset asserted (rst=0) in DRAIN with 4 records pending -> next cycle out_valid=0, counters 0, done=0, a new commit gets inum 0.
- inst_count preloaded via 65535 NOP commits plus 1 more -> wraps to 0; drop_cnt saturates at 0xFFFF under sustained overflow.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace buffer: record kinds, FSM states,
// record width and the retire classifier.
package trace_pkg;

    localparam int KIND_W    = 3;
    localparam int FIELD_W   = 16;
    localparam int REG_IDX_W = 3;

    localparam logic [KIND_W-1:0] KIND_NOP  = 3'd1;
    localparam logic [KIND_W-1:0] KIND_REG  = 3'd2;
    localparam logic [KIND_W-1:0] KIND_LD   = 3'd3;
    localparam logic [KIND_W-1:0] KIND_ST   = 3'd4;
    localparam logic [KIND_W-1:0] KIND_STU  = 3'd5;
    localparam logic [KIND_W-1:0] KIND_HALT = 3'd6;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_PEND = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    // Record layout: kind, inum, pc, reg, rdata, addr, mdata (MSB first).
    function automatic int rec_w(input int cnt_w);
        return KIND_W + cnt_w + FIELD_W + REG_IDX_W + FIELD_W + FIELD_W + FIELD_W;
    endfunction

    localparam int REC_W = rec_w(16);

    // Register writes take precedence over halt; a halting core must not
    // also write a register in the same cycle.
    function automatic logic [KIND_W-1:0] classify(input logic reg_write,
                                                   input logic mem_read,
                                                   input logic mem_write,
                                                   input logic halt);
        logic [KIND_W-1:0] kind;
        if (reg_write && mem_write)     kind = KIND_STU;
        else if (reg_write && mem_read) kind = KIND_LD;
        else if (reg_write)             kind = KIND_REG;
        else if (halt)                  kind = KIND_HALT;
        else if (mem_write)             kind = KIND_ST;
        else                            kind = KIND_NOP;
        return kind;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO for the trace buffer. Read data comes straight from the storage
// flops, so the head record is stable until it is popped.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int REC_W_P  = trace_pkg::REC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [REC_W_P-1:0] push_data,
    input  logic               pop,
    output logic [REC_W_P-1:0] pop_data,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [REC_W_P-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               do_push, do_pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign do_pop   = pop & ~empty;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retire-trace capture: classifies each committed instruction, packs a record
// into a FIFO drained over valid/ready, and terminates cleanly on halt.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit_valid,
    input  logic [15:0]      pc,
    input  logic [15:0]      inst,
    input  logic             reg_write,
    input  logic [2:0]       write_reg,
    input  logic [15:0]      write_data,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      mem_data,
    input  logic             halt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_kind,
    output logic [CNT_W-1:0] out_inum,
    output logic [15:0]      out_pc,
    output logic [15:0]      out_rdata,
    output logic [15:0]      out_addr,
    output logic [15:0]      out_mdata,
    output logic [2:0]       out_reg,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow,
    output logic             done
);

    localparam int RW = rec_w(CNT_W);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] inst_count_q, inst_count_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;
    logic [RW-1:0]    skid_q, skid_d;

    logic [KIND_W-1:0] kind;
    logic [RW-1:0]     new_rec;
    logic [RW-1:0]     push_data;
    logic [RW-1:0]     pop_data;
    logic              push;
    logic              fifo_full, fifo_empty;
    logic              deq, can_enq;
    logic [15:0]       inst_unused;

    logic [KIND_W-1:0] rec_kind;
    logic [CNT_W-1:0]  rec_inum;
    logic [15:0]       rec_pc, rec_rdata, rec_addr, rec_mdata;
    logic [2:0]        rec_reg;

    assign inst_unused = inst;

    trace_fifo #(
        .DEPTH   (DEPTH),
        .REC_W_P (RW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (deq),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign deq       = out_valid & out_ready;
    assign can_enq   = ~fifo_full | deq;

    // Fields irrelevant to the record kind are zeroed before packing.
    always_comb begin
        logic [2:0]  f_reg;
        logic [15:0] f_rdata, f_addr, f_mdata;
        kind    = classify(reg_write, mem_read, mem_write, halt);
        f_reg   = '0;
        f_rdata = '0;
        f_addr  = '0;
        f_mdata = '0;
        case (kind)
            KIND_REG: begin
                f_reg   = write_reg;
                f_rdata = write_data;
            end
            KIND_LD: begin
                f_reg   = write_reg;
                f_rdata = write_data;
                f_addr  = mem_addr;
            end
            KIND_ST: begin
                f_addr  = mem_addr;
                f_mdata = mem_data;
            end
            KIND_STU: begin
                f_reg   = write_reg;
                f_rdata = write_data;
                f_addr  = mem_addr;
                f_mdata = mem_data;
            end
            default: ;
        endcase
        new_rec = {kind, inst_count_q, pc, f_reg, f_rdata, f_addr, f_mdata};
    end

    always_comb begin
        state_d      = state_q;
        inst_count_d = inst_count_q;
        drop_cnt_d   = drop_cnt_q;
        overflow_d   = overflow_q;
        skid_d       = skid_q;
        push         = 1'b0;
        push_data    = new_rec;
        case (state_q)
            ST_RUN: begin
                if (commit_valid) begin
                    inst_count_d = inst_count_q + CNT_W'(1);
                    if (kind == KIND_HALT) begin
                        if (can_enq) begin
                            push    = 1'b1;
                            state_d = ST_DRAIN;
                        end else begin
                            skid_d  = new_rec;
                            state_d = ST_HALT_PEND;
                        end
                    end else if (can_enq) begin
                        push = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                        if (drop_cnt_q != {CNT_W{1'b1}}) begin
                            drop_cnt_d = drop_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_HALT_PEND: begin
                push_data = skid_q;
                if (can_enq) begin
                    push    = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: ;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            inst_count_q <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_count_q <= inst_count_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    // Head-of-FIFO fields are forced to zero whenever no record is offered.
    assign {rec_kind, rec_inum, rec_pc, rec_reg, rec_rdata, rec_addr, rec_mdata} = pop_data;

    assign out_kind   = out_valid ? rec_kind  : '0;
    assign out_inum   = out_valid ? rec_inum  : '0;
    assign out_pc     = out_valid ? rec_pc    : '0;
    assign out_reg    = out_valid ? rec_reg   : '0;
    assign out_rdata  = out_valid ? rec_rdata : '0;
    assign out_addr   = out_valid ? rec_addr  : '0;
    assign out_mdata  = out_valid ? rec_mdata : '0;

    assign inst_count = inst_count_q;
    assign drop_cnt   = drop_cnt_q;
    assign overflow   = overflow_q;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed vector table,
// hand-written corner sequences and a randomized run against a queue model.
module tb_commit_trace_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             commit_valid;
    logic [15:0]      pc, inst;
    logic             reg_write;
    logic [2:0]       write_reg;
    logic [15:0]      write_data;
    logic             mem_read, mem_write;
    logic [15:0]      mem_addr, mem_data;
    logic             halt;
    logic             out_valid, out_ready;
    logic [2:0]       out_kind, out_reg;
    logic [CNT_W-1:0] out_inum, inst_count, drop_cnt;
    logic [15:0]      out_pc, out_rdata, out_addr, out_mdata;
    logic             overflow, done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .pc(pc), .inst(inst),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data(mem_data), .halt(halt), .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_inum(out_inum), .out_pc(out_pc), .out_rdata(out_rdata),
        .out_addr(out_addr), .out_mdata(out_mdata), .out_reg(out_reg),
        .inst_count(inst_count), .drop_cnt(drop_cnt), .overflow(overflow), .done(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        commit_valid = 0; pc = 0; inst = 0; reg_write = 0; write_reg = 0;
        write_data = 0; mem_read = 0; mem_write = 0; mem_addr = 0; mem_data = 0; halt = 0;
    endtask

    task automatic nop_commit(input logic [15:0] p);
        idle_inputs();
        commit_valid = 1; pc = p; inst = 16'hA5A5;
    endtask

    task automatic do_reset();
        rst = 0; out_ready = 0; idle_inputs();
        @(negedge clk);
        rst = 1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic cv; logic [15:0] pc; logic rw; logic [2:0] wreg; logic [15:0] wdata;
        logic mr; logic mw; logic [15:0] addr; logic [15:0] mdata; logic h;
        logic e_valid; logic [2:0] e_kind; logic [15:0] e_inum; logic [15:0] e_pc;
        logic [2:0] e_reg; logic [15:0] e_rdata; logic [15:0] e_addr; logic [15:0] e_mdata;
        logic [15:0] e_icount;
    } vec_t;

    vec_t vecs [4];

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0] kind; int inum; logic [15:0] pc; logic [2:0] rg;
        logic [15:0] rdata; logic [15:0] addr; logic [15:0] mdata;
    } rec_t;

    rec_t mq[$];
    rec_t m_skid;
    int   m_mode;   // 0 accepting, 1 halt waiting, 2 draining, 3 finished
    int   m_cnt, m_drop;
    bit   m_ovf;

    function automatic rec_t model_rec(input int inum);
        rec_t r;
        if (reg_write && mem_write)     r.kind = 5;
        else if (reg_write && mem_read) r.kind = 3;
        else if (reg_write)             r.kind = 2;
        else if (halt)                  r.kind = 6;
        else if (mem_write)             r.kind = 4;
        else                            r.kind = 1;
        r.inum  = inum;
        r.pc    = pc;
        r.rg    = (r.kind inside {3'd2, 3'd3, 3'd5}) ? write_reg  : 3'd0;
        r.rdata = (r.kind inside {3'd2, 3'd3, 3'd5}) ? write_data : 16'd0;
        r.addr  = (r.kind inside {3'd3, 3'd4, 3'd5}) ? mem_addr   : 16'd0;
        r.mdata = (r.kind inside {3'd4, 3'd5})       ? mem_data   : 16'd0;
        return r;
    endfunction

    task automatic model_clear();
        mq.delete(); m_mode = 0; m_cnt = 0; m_drop = 0; m_ovf = 0;
    endtask

    // Advances the model across the upcoming clock edge using current inputs.
    task automatic model_step();
        rec_t r;
        bit was_empty;
        if (!rst) begin
            model_clear();
            return;
        end
        was_empty = (mq.size() == 0);
        if (!was_empty && out_ready) void'(mq.pop_front());
        case (m_mode)
            0: if (commit_valid) begin
                r = model_rec(m_cnt);
                m_cnt = (m_cnt + 1) % 65536;
                if (r.kind == 6) begin
                    if (mq.size() < DEPTH) begin mq.push_back(r); m_mode = 2; end
                    else begin m_skid = r; m_mode = 1; end
                end else if (mq.size() < DEPTH) begin
                    mq.push_back(r);
                end else begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end
            end
            1: if (mq.size() < DEPTH) begin mq.push_back(m_skid); m_mode = 2; end
            2: if (was_empty) m_mode = 3;
            default: ;
        endcase
    endtask

    task automatic model_compare(input int cyc);
        rec_t h;
        string s;
        bit v;
        v = (mq.size() > 0);
        if (v) h = mq[0];
        else begin h.kind = 0; h.inum = 0; h.pc = 0; h.rg = 0; h.rdata = 0; h.addr = 0; h.mdata = 0; end
        s = $sformatf("rand%0d", cyc);
        check({s, " valid"}, out_valid, v);
        check({s, " kind"},  out_kind,  h.kind);
        check({s, " inum"},  out_inum,  h.inum);
        check({s, " pc"},    out_pc,    h.pc);
        check({s, " reg"},   out_reg,   h.rg);
        check({s, " rdata"}, out_rdata, h.rdata);
        check({s, " addr"},  out_addr,  h.addr);
        check({s, " mdata"}, out_mdata, h.mdata);
        check({s, " icnt"},  inst_count, m_cnt);
        check({s, " drop"},  drop_cnt,  m_drop);
        check({s, " ovf"},   overflow,  m_ovf);
        check({s, " done"},  done,      m_mode == 3);
    endtask

    initial begin
        rst = 0; out_ready = 0; idle_inputs();
        repeat (2) @(negedge clk);

        // Reset state
        check("rst out_valid", out_valid, 0);
        check("rst inst_count", inst_count, 0);
        check("rst drop_cnt", drop_cnt, 0);
        check("rst overflow", overflow, 0);
        check("rst done", done, 0);
        check("rst out_kind", out_kind, 0);
        rst = 1;

        // ---- Table: REG, LD, ST with sink always ready ----
        vecs[0] = '{1'b1, 16'h0000, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 16'h0F0F, 16'h3333, 1'b0,
                    1'b1, 3'd2, 16'd0, 16'h0000, 3'd3, 16'h1234, 16'h0000, 16'h0000, 16'd1};
        vecs[1] = '{1'b1, 16'h0002, 1'b1, 3'd1, 16'h00AA, 1'b1, 1'b0, 16'h0100, 16'h4444, 1'b0,
                    1'b1, 3'd3, 16'd1, 16'h0002, 3'd1, 16'h00AA, 16'h0100, 16'h0000, 16'd2};
        vecs[2] = '{1'b1, 16'h0004, 1'b0, 3'd5, 16'h5555, 1'b0, 1'b1, 16'h0200, 16'hBEEF, 1'b0,
                    1'b1, 3'd4, 16'd2, 16'h0004, 3'd0, 16'h0000, 16'h0200, 16'hBEEF, 16'd3};
        vecs[3] = '{1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0,
                    1'b0, 3'd0, 16'd0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'd3};
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            commit_valid = vecs[i].cv; pc = vecs[i].pc; inst = 16'h1111 * i[15:0];
            reg_write = vecs[i].rw; write_reg = vecs[i].wreg; write_data = vecs[i].wdata;
            mem_read = vecs[i].mr; mem_write = vecs[i].mw; mem_addr = vecs[i].addr;
            mem_data = vecs[i].mdata; halt = vecs[i].h;
            @(negedge clk);
            check($sformatf("vec%0d valid", i), out_valid, vecs[i].e_valid);
            check($sformatf("vec%0d kind", i),  out_kind,  vecs[i].e_kind);
            check($sformatf("vec%0d inum", i),  out_inum,  vecs[i].e_inum);
            check($sformatf("vec%0d pc", i),    out_pc,    vecs[i].e_pc);
            check($sformatf("vec%0d reg", i),   out_reg,   vecs[i].e_reg);
            check($sformatf("vec%0d rdata", i), out_rdata, vecs[i].e_rdata);
            check($sformatf("vec%0d addr", i),  out_addr,  vecs[i].e_addr);
            check($sformatf("vec%0d mdata", i), out_mdata, vecs[i].e_mdata);
            check($sformatf("vec%0d icnt", i),  inst_count, vecs[i].e_icount);
        end

        // ---- Overflow: 10 NOPs into a stalled sink ----
        do_reset();
        for (int i = 0; i < 10; i++) begin
            nop_commit(16'(i * 2));
            @(negedge clk);
        end
        idle_inputs();
        check("ovf drop_cnt", drop_cnt, 2);
        check("ovf overflow", overflow, 1);
        check("ovf inst_count", inst_count, 10);
        @(negedge clk);
        check("ovf stable inum", out_inum, 0);
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf drain%0d valid", i), out_valid, 1);
            check($sformatf("ovf drain%0d inum", i), out_inum, i);
            @(negedge clk);
        end
        check("ovf drained", out_valid, 0);
        check("ovf sticky", overflow, 1);

        // ---- Full FIFO with simultaneous enqueue and dequeue ----
        do_reset();
        for (int i = 0; i < 8; i++) begin
            nop_commit(16'(i));
            @(negedge clk);
        end
        nop_commit(16'h0077);
        out_ready = 1;
        @(negedge clk);
        idle_inputs();
        check("simul drop_cnt", drop_cnt, 0);
        check("simul overflow", overflow, 0);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("simul rd%0d inum", i), out_inum, i);
            @(negedge clk);
        end
        check("simul drained", out_valid, 0);

        // ---- HALT while full: held, then delivered last ----
        do_reset();
        for (int i = 0; i < 8; i++) begin
            nop_commit(16'(i));
            @(negedge clk);
        end
        idle_inputs(); commit_valid = 1; halt = 1; pc = 16'h0010;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            nop_commit(16'h0100);
            @(negedge clk);
        end
        idle_inputs();
        check("halt icnt frozen", inst_count, 9);
        check("halt no drop", drop_cnt, 0);
        check("halt done early", done, 0);
        check("halt head inum", out_inum, 0);
        out_ready = 1;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("halt rd%0d inum", i), out_inum, i);
            check($sformatf("halt rd%0d kind", i), out_kind, (i == 8) ? 6 : 1);
            if (i == 8) check("halt rec pc", out_pc, 16'h0010);
            @(negedge clk);
        end
        check("halt empty", out_valid, 0);
        check("halt done pre", done, 0);
        @(negedge clk);
        check("halt done", done, 1);
        nop_commit(16'h0200);
        @(negedge clk);
        idle_inputs();
        check("done ignores commit", inst_count, 9);
        check("done no record", out_valid, 0);

        // ---- Reset during DRAIN with 4 pending ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            nop_commit(16'(i));
            @(negedge clk);
        end
        idle_inputs(); commit_valid = 1; halt = 1; pc = 16'h0020;
        @(negedge clk);
        idle_inputs();
        check("drain icnt", inst_count, 4);
        rst = 0;
        @(negedge clk);
        rst = 1;
        check("mid rst valid", out_valid, 0);
        check("mid rst icnt", inst_count, 0);
        check("mid rst done", done, 0);
        nop_commit(16'h0030);
        out_ready = 1;
        @(negedge clk);
        idle_inputs();
        check("post rst valid", out_valid, 1);
        check("post rst inum", out_inum, 0);

        // ---- Randomized run against the model ----
        do_reset();
        model_clear();
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 99) != 0);
            commit_valid = ($urandom_range(0, 9) < 7);
            pc           = 16'($urandom);
            inst         = 16'($urandom);
            reg_write    = ($urandom_range(0, 9) < 4);
            write_reg    = 3'($urandom);
            write_data   = 16'($urandom);
            mem_read     = ($urandom_range(0, 9) < 3);
            mem_write    = ($urandom_range(0, 9) < 3);
            mem_addr     = 16'($urandom);
            mem_data     = 16'($urandom);
            halt         = ($urandom_range(0, 39) == 0);
            out_ready    = ($urandom_range(0, 1) == 1);
            model_step();
            @(negedge clk);
            model_compare(c);
        end

        // ---- Counter wrap and drop saturation ----
        do_reset();
        nop_commit(16'h0040);
        repeat (65536) @(negedge clk);
        check("wrap inst_count", inst_count, 0);
        check("wrap drop_cnt", drop_cnt, 65528);
        repeat (10) @(negedge clk);
        idle_inputs();
        check("sat drop_cnt", drop_cnt, 16'hFFFF);
        check("sat inst_count", inst_count, 10);
        check("sat overflow", overflow, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
